// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register byte offsets within the peripheral window
//   - bit positions of the STATUS register fields
//   - transmit FSM state type
//   - BAUDDIV write clamp (a divider of 0 is not meaningful, so it becomes 1)
package uart_tx_pkg;

  localparam logic [3:0] TXDATA  = 4'h0;
  localparam logic [3:0] STATUS  = 4'h4;
  localparam logic [3:0] BAUDDIV = 4'h8;

  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_W   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

  function automatic logic [15:0] clamp_bauddiv(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, one push and one pop per cycle.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   i_push, i_wdata     write request and data
//   i_pop               read request; o_rdata is the current head entry
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries (0..DEPTH)
//   o_drop              push refused this cycle (full with no simultaneous pop)
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && o_full && !w_do_pop;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter on the core's load/store bus.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_bus_addr       byte offset (bits [1:0] ignored): 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV
//   i_bus_wren       store strobe
//   i_bus_rden       load strobe, gates o_bus_rdata
//   i_bus_wdata      store data
//   o_bus_rdata      combinational load data
//   o_uart_tx        registered serial line, idle high
//   o_irq            registered; high once the line is idle with nothing queued
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_BAUDDIV = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_bus_addr,
  input  logic        i_bus_wren,
  input  logic        i_bus_rden,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_uart_tx,
  output logic        o_irq
);

  localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic [3:0]     w_reg_sel;
  logic           w_txdata_wr;
  logic           w_status_wr;
  logic           w_baud_wr;
  logic           w_pop;
  logic           w_drop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [7:0]     w_fifo_rdata;
  logic           w_bit_end;
  logic           w_busy;
  logic [31:0]    w_status;
  logic           w_unused;

  logic [15:0]    r_bauddiv;
  logic           r_ovf;
  uart_tx_state_e r_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic [15:0]    r_baudcnt;
  logic           r_tx;
  logic           r_irq;

  assign w_unused = ^{i_bus_addr[1:0], i_bus_wdata[31:16]};

  assign w_reg_sel   = {i_bus_addr[3:2], 2'b00};
  assign w_txdata_wr = i_bus_wren && (w_reg_sel == TXDATA);
  assign w_status_wr = i_bus_wren && (w_reg_sel == STATUS);
  assign w_baud_wr   = i_bus_wren && (w_reg_sel == BAUDDIV);

  assign w_bit_end = (r_baudcnt == 16'd0);
  assign w_busy    = (r_state != IDLE);
  // Head is consumed when a frame starts from idle or back-to-back after a stop bit.
  assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_txdata_wr),
    .i_wdata (i_bus_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bauddiv <= DEFAULT_BAUDDIV;
      r_ovf     <= 1'b0;
    end else begin
      if (w_baud_wr) begin
        r_bauddiv <= clamp_bauddiv(i_bus_wdata[15:0]);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_status_wr && i_bus_wdata[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Each bit lasts r_bauddiv cycles: the counter is loaded with div-1 at a bit
  // boundary and the next boundary is the edge where it has reached zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_baudcnt <= 16'd0;
      r_tx      <= 1'b1;
      r_irq     <= 1'b1;
    end else begin
      r_irq <= (r_state == IDLE) && w_empty;
      unique case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift   <= w_fifo_rdata;
            r_baudcnt <= r_bauddiv - 16'd1;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bitcnt  <= 3'd0;
            r_baudcnt <= r_bauddiv - 16'd1;
            r_state   <= DATA;
          end else begin
            r_baudcnt <= r_baudcnt - 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baudcnt <= r_bauddiv - 16'd1;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else begin
            r_baudcnt <= r_baudcnt - 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (!w_empty) begin
              r_shift   <= w_fifo_rdata;
              r_baudcnt <= r_bauddiv - 16'd1;
              r_tx      <= 1'b0;
              r_state   <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baudcnt <= r_baudcnt - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_status = 32'h0;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_BUSY]  = w_busy;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
  end

  always_comb begin
    o_bus_rdata = 32'h0;
    if (i_bus_rden) begin
      case (w_reg_sel)
        STATUS:  o_bus_rdata = w_status;
        BAUDDIV: o_bus_rdata = {16'h0, r_bauddiv};
        default: o_bus_rdata = 32'h0;
      endcase
    end
  end

  assign o_uart_tx = r_tx;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: randomized and directed stimulus for uart_tx_periph.
// The reference model schedules every accepted byte as a frame (start cycle and
// per-bit durations) from the FIFO occupancy and line-availability rules; a
// separate monitor decodes o_uart_tx and compares each frame against the queue.
module tb_uart_tx_periph;

  localparam int DEPTH  = 8;
  localparam int DEFDIV = 434;

  typedef struct {
    logic [7:0] data;
    int         start;
    int         da;
    int         sw;
    int         db;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_acc = 0;
  int frames_started = 0;
  bit in_frame = 1'b0;

  frame_t exp_q[$];
  frame_t hist[$];
  int     model_div = DEFDIV;
  bit     model_ovf = 1'b0;

  uart_tx_periph #(
    .FIFO_DEPTH      (DEPTH),
    .DEFAULT_BAUDDIV (16'd434)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_bus_addr  (addr),
    .i_bus_wren  (wren),
    .i_bus_rden  (rden),
    .i_bus_wdata (wdata),
    .o_bus_rdata (rdata),
    .o_uart_tx   (tx),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int flen(input frame_t f);
    return f.sw * f.da + (10 - f.sw) * f.db;
  endfunction

  function automatic int last_end();
    int e = 0;
    foreach (hist[i]) if (hist[i].start + flen(hist[i]) > e) e = hist[i].start + flen(hist[i]);
    return e;
  endfunction

  // Bytes held in the FIFO after edge n: accepted but not yet started.
  function automatic int pend(input int n);
    int c = 0;
    foreach (hist[i]) if (hist[i].start > n) c++;
    return c;
  endfunction

  function automatic bit busy_at(input int n);
    foreach (hist[i]) if (hist[i].start <= n && n < hist[i].start + flen(hist[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit popped_at(input int n);
    foreach (hist[i]) if (hist[i].start == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_status(input int n);
    int c = pend(n);
    logic [31:0] s = 32'h0;
    s[7:4] = 4'(c);
    s[3]   = model_ovf;
    s[2]   = busy_at(n);
    s[1]   = (c == 0);
    s[0]   = (c == DEPTH);
    return s;
  endfunction

  function automatic logic exp_irq(input int n);
    return !busy_at(n - 1) && (pend(n - 1) == 0);
  endfunction

  function automatic void model_push(input int n, input logic [7:0] d, input int da,
                                     input int sw, input int db);
    frame_t f;
    int le;
    if (pend(n - 1) < DEPTH || popped_at(n)) begin
      le = last_end();
      f.data = d;
      f.da = da;
      f.sw = sw;
      f.db = db;
      f.start = (n + 1 > le) ? n + 1 : le;
      hist.push_back(f);
      exp_q.push_back(f);
      n_acc++;
    end else begin
      model_ovf = 1'b1;
    end
  endfunction

  function automatic logic exp_level(input frame_t f, input int k);
    int acc = 0;
    for (int j = 0; j < 10; j++) begin
      int d = (j < f.sw) ? f.da : f.db;
      if (k < acc + d) begin
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return f.data[j-1];
      end
      acc += d;
    end
    return 1'b1;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int en);
    addr = a;
    wdata = d;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
    en = cyc;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    rden = 1'b1;
    #1;
    d = rdata;
    rden = 1'b0;
    #1;
  endtask

  task automatic push_ov(input logic [7:0] d, input int da, input int sw, input int db);
    int n;
    wr(4'h0, {24'h0, d}, n);
    model_push(n, d, da, sw, db);
  endtask

  task automatic push(input logic [7:0] d);
    push_ov(d, model_div, 10, model_div);
  endtask

  task automatic set_div(input logic [31:0] v);
    int n;
    wr(4'h8, v, n);
    model_div = (v[15:0] == 16'd0) ? 1 : int'(v[15:0]);
  endtask

  task automatic clear_ovf();
    int n;
    wr(4'h4, 32'h8, n);
    model_ovf = 1'b0;
  endtask

  task automatic check_status(input string name);
    logic [31:0] s;
    rd(4'h4, s);
    check({name, "_status"}, s, exp_status(cyc));
    check({name, "_irq"}, {31'h0, irq}, {31'h0, exp_irq(cyc)});
  endtask

  task automatic wait_idle();
    int t = last_end() + 2;
    while (cyc < t) sync();
  endtask

  // ---------------- monitor ----------------
  initial begin
    frame_t cur;
    int k = 0;
    int bad = 0;
    int tot = 0;
    bit spur = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        spur = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            if (!spur) check("idle_line", {31'h0, tx}, 32'h1);
            spur = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            frames_started++;
            check($sformatf("start_cycle_%02h", cur.data), cyc, cur.start);
            in_frame = 1'b1;
            k = 0;
            bad = 0;
            tot = flen(cur);
          end
        end else if (!in_frame) begin
          spur = 1'b0;
        end
        if (in_frame) begin
          if (tx !== exp_level(cur, k)) bad++;
          k++;
          if (k == tot) begin
            in_frame = 1'b0;
            check($sformatf("frame_wave_%02h_badcycles", cur.data), bad, 0);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int n;
    int lows;
    int budget;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h1);
    #2 rst_n = 1'b1;
    sync();
    rd(4'h8, v);
    check("rst_bauddiv", v, 32'd434);
    rd(4'h4, v);
    check("rst_status", v, 32'h2);
    sync();
    rd(4'h0, v);
    check("txdata_reads_zero", v, 32'h0);
    rd(4'hC, v);
    check("reserved_reads_zero", v, 32'h0);
    addr = 4'h8;
    #1;
    check("rden_gate", rdata, 32'h0);
    sync();

    // Single frame at BAUDDIV=4
    set_div(32'd4);
    push(8'hA5);
    repeat (20) sync();
    check_status("t2_mid");
    wait_idle();
    check_status("t2_done");

    // Back-to-back frames, no idle gap
    push(8'h55);
    push(8'h0F);
    wait_idle();
    check_status("t3_done");

    // Overflow: 10 pushes into an 8-deep FIFO
    set_div(32'd2);
    for (int i = 0; i < 10; i++) push(8'($urandom));
    check_status("t4_full");
    clear_ovf();
    check_status("t4_ovfclr");
    wait_idle();

    // Reset in the middle of a frame
    set_div(32'd4);
    push(8'h3C);
    repeat (20) sync();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_tx", {31'h0, tx}, 32'h1);
    check("t5_async_irq", {31'h0, irq}, 32'h1);
    n_acc -= exp_q.size();
    exp_q.delete();
    hist.delete();
    model_ovf = 1'b0;
    model_div = DEFDIV;
    repeat (2) sync();
    #2 rst_n = 1'b1;
    sync();
    rd(4'h4, v);
    check("t5_status", v, 32'h2);
    rd(4'h8, v);
    check("t5_bauddiv", v, 32'd434);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_residual_lows", lows, 0);
    sync();

    // Divider change mid-bit: start,b0,b1,b2 at 4 cycles, b3..stop at 8
    set_div(32'd4);
    push_ov(8'h96, 4, 4, 8);
    repeat (13) sync();
    set_div(32'd8);
    wait_idle();
    set_div(32'd0);
    rd(4'h8, v);
    check("t6_div_zero_clamp", v, 32'd1);
    sync();

    // Randomized traffic
    set_div(32'd3);
    for (int it = 0; it < 80; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 8 && !busy_at(cyc) && pend(cyc) == 0) begin
        set_div(32'($urandom_range(1, 5)));
      end else if (r < 14) begin
        check_status("rnd");
        sync();
      end else if (r < 17) begin
        clear_ovf();
      end else begin
        int g;
        push(8'($urandom));
        g = (r > 92) ? $urandom_range(0, 60) : $urandom_range(0, 2);
        repeat (g) sync();
      end
    end

    budget = 0;
    while ((exp_q.size() != 0 || in_frame) && budget < 20000) begin
      sync();
      budget++;
    end
    check("drain_pending", exp_q.size() + int'(in_frame), 0);
    check("frame_count", frames_started, n_acc);
    sync();
    check_status("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
